// File: rtl/multi_pkg.sv
`default_nettype none
// multi_pkg: shared types and defaults for the multi-cycle datapath front end.
// Revision: 1.0
package multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } multi_issue_state_t;

  localparam int MULTI_WIDTH   = 64;
  localparam int MULTI_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/multi_issue_watchdog.sv
`default_nettype none
// multi_issue_watchdog: counts WAIT cycles from the start cycle and flags expiry
// once TIMEOUT cycles have elapsed without completion. Revision: 1.0
module multi_issue_watchdog
  import multi_pkg::*;
#(
  parameter int TIMEOUT = MULTI_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The counter reads 0 in the start cycle, so expiry lands in the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/multi_issue_adapter.sv
`default_nettype none
// multi_issue_adapter: valid/ready front end for a start/done multi-cycle datapath.
// Optional timeout watchdog: define MULTI_ISSUE_WATCHDOG_EN. Revision: 1.0
module multi_issue_adapter
  import multi_pkg::*;
#(
  parameter int WIDTH   = MULTI_WIDTH,
  parameter int TIMEOUT = MULTI_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             start,
  output logic [WIDTH-1:0] inp,
  input  logic             done,
  input  logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  multi_issue_state_t state;

  logic accept;
  logic capture;
  logic expire;

  assign in_ready = !reset && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  // start is high exactly in the first WAIT cycle, where done cannot be genuine.
  assign capture  = (state == WAIT) && !start && done;

`ifdef MULTI_ISSUE_WATCHDOG_EN
  logic waiting;
  assign waiting = (state == WAIT);

  multi_issue_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .run    (waiting),
    .expired(expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (expire && !capture) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      start     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      inp       <= '0;
      out_data  <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            inp   <= in_data;
            start <= 1'b1;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (capture) begin
            out_data  <= out;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (expire) begin
            out_data  <= '1;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              inp   <= in_data;
              start <= 1'b1;
              busy  <= 1'b1;
              state <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/multi_issue_adapter.md
# multi_issue_adapter

Front-end stage that feeds the 64-bit multi-cycle start/done datapath (the dual-lane `multi0` wrapper) from a valid/ready stream and returns its results as a valid/ready stream. It accepts one operand, issues a single-cycle `start` with a stable operand, and waits for `done`. It then holds the result until the consumer takes it. At most one operation is outstanding, so the wrapped unit is never restarted while running.

## Interface
Parameters:
- WIDTH, 64, operand/result width
- TIMEOUT, 255, max cycles from `start` to `done` before abort (used only with watchdog compiled in)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream operand valid
- in_ready  out  1  adapter can accept operand
- in_data  in  WIDTH  operand
- start  out  1  one-cycle start pulse to datapath
- inp  out  WIDTH  operand to datapath, registered
- done  in  1  datapath result valid, one-cycle pulse
- out  in  WIDTH  datapath result, valid only with `done`
- out_valid  out  1  result available downstream
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  held result
- busy  out  1  operation outstanding (WAIT state)
- err  out  1  sticky timeout flag; constant 0 without watchdog

## Operation
- States: IDLE, WAIT, HOLD (encoded in package enum).
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_data into inp;
  - set start for the next cycle;
  - go to WAIT.
- WAIT:
  - start=1 in the first WAIT cycle only.
  - busy=1.
  - done in the start cycle is ignored: the datapath never completes in zero cycles.
  - done in a later cycle: latch out into the result register and go to HOLD.
- HOLD: out_valid=1, out_data=result register.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: in_ready=1 and the new operand is accepted in the same cycle (back-to-back). Go directly to WAIT with start=1 next cycle.
  - out_ready=0: hold. in_ready=0, and out_data stays stable.
- in_ready = (state==IDLE) | (state==HOLD & out_ready); forced 0 while reset is asserted.
- done outside WAIT, or in the start cycle, is ignored. Adapter state and outputs do not change.
- inp stays stable from the start cycle until the next acceptance.

## Timing
- Reset values: start=0, out_valid=0, busy=0, err=0, inp=0, out_data=0, state=IDLE.
- Operand handshake in cycle c0 → start=1 in c1.
- With done in cycle c1+D (D≥1), out_valid=1 in c2+D. Minimum handshake-to-result latency is 3 cycles.
- Back-to-back sustained throughput is one operation per D+2 cycles.
- Reset mid-operation: the next cycle is IDLE, the pending result is discarded and start=0. A done arriving after reset is ignored.

## Configuration
- MULTI_ISSUE_WATCHDOG_EN compiled in:
  - A counter runs in WAIT starting from the start cycle.
  - If it reaches TIMEOUT with no done, err sets (sticky until reset).
  - The FSM goes to HOLD with out_data = all ones.
  - A late done is ignored.
  - The datapath must be reset before trusting further results.
- Without MULTI_ISSUE_WATCHDOG_EN: no counter exists, err is tied to 0, and WAIT waits indefinitely.

## Structure
- Shared package `multi_pkg`:
  - state enum `multi_issue_state_t` {IDLE, WAIT, HOLD};
  - default width constant `MULTI_WIDTH`=64;
  - timeout default `MULTI_TIMEOUT`=255.
- One sub-module, `multi_issue_watchdog`, holds the counter and the expiry compare. It is instantiated only under MULTI_ISSUE_WATCHDOG_EN.

## Test plan
- Single op:
  - stimulus: in_data=64'h0000_0003_0000_0005 accepted at c0; done at c3 with out=64'hAAAA_BBBB_CCCC_DDDD.
  - response: start=1 only at c1; inp stable; out_valid=1 at c4 with that value; busy=1 during c1–c3.
- Zero-cycle guard: done=1 in the start cycle, then done=1 two cycles later with out=64'h1234 → only the second done is captured; out_data=64'h1234.
- Backpressure + back-to-back:
  - stimulus: out_ready=0 for 5 cycles in HOLD, then out_ready=1 with in_valid=1 and in_data=64'h7.
  - response: out_data constant while held; new operand accepted in the release cycle; start=1 in the next cycle.
- Spurious done:
  - stimulus: done=1 with out=64'hFFFF while IDLE and while in HOLD.
  - response: no state change; out_valid is not raised in IDLE; out_data is unchanged in HOLD.
- Reset mid-WAIT:
  - stimulus: reset at the 2nd WAIT cycle, then done=1.
  - response: IDLE, out_valid=0, start=0; the done is ignored.
- Watchdog (macro on, TIMEOUT=4): no done after start → err=1 and out_valid=1 with out_data=64'hFFFF_FFFF_FFFF_FFFF. A later done is ignored, and err stays 1 until reset.
